// File: rtl/round_controller_if.sv
// rtl/round_controller_if.sv - control/status bundle between the round controller and the game logic
// master: drives start/abort/tick/alive, observes controller status
// slave : the round controller itself
interface round_controller_if #(
    parameter int NUM_PLAYERS   = 4,
    parameter int NUM_BLOCKS    = 15,
    parameter int ROUND_TICKS   = 180,
    parameter int WINS_TO_MATCH = 3
);
    localparam int AW = $clog2(NUM_BLOCKS);
    localparam int TW = $clog2(ROUND_TICKS + 1);
    localparam int W  = $clog2(WINS_TO_MATCH + 1);

    logic                     start;
    logic                     abort;
    logic                     tick;
    logic [NUM_PLAYERS-1:0]   alive;
    logic [2:0]               state;
    logic                     init_we;
    logic [AW-1:0]            init_addr;
    logic [TW-1:0]            time_left;
    logic                     round_done;
    logic [2:0]               round_winner;
    logic [NUM_PLAYERS*W-1:0] wins;
    logic [2:0]               match_winner;

    modport master (
        output start, abort, tick, alive,
        input  state, init_we, init_addr, time_left, round_done,
               round_winner, wins, match_winner
    );

    modport slave (
        input  start, abort, tick, alive,
        output state, init_we, init_addr, time_left, round_done,
               round_winner, wins, match_winner
    );
endinterface

// File: rtl/round_controller.sv
// rtl/round_controller.sv - match/round sequencer: block-map init, round timer, winner and score keeping
// clk   : sole clock, rising edge
// reset : synchronous, active-low
// bus   : round_controller_if.slave (start/abort/tick/alive in; state, init_we/init_addr,
//         time_left, round_done, round_winner, wins, match_winner out)
module round_controller #(
    parameter int NUM_PLAYERS   = 4,
    parameter int NUM_BLOCKS    = 15,
    parameter int ROUND_TICKS   = 180,
    parameter int WINS_TO_MATCH = 3
) (
    input  logic              clk,
    input  logic              reset,
    round_controller_if.slave bus
);
    localparam int AW = $clog2(NUM_BLOCKS);
    localparam int TW = $clog2(ROUND_TICKS + 1);
    localparam int W  = $clog2(WINS_TO_MATCH + 1);

    localparam logic [2:0]    DRAW      = 3'd7;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_BLOCKS - 1);
    localparam logic [TW-1:0] FULL_TIME = TW'(ROUND_TICKS);
    localparam logic [W-1:0]  MATCH_WIN = W'(WINS_TO_MATCH);

    typedef enum logic [2:0] {
        MENU      = 3'd0,
        INIT      = 3'd1,
        PLAYING   = 3'd2,
        ROUND_END = 3'd3,
        MATCH_END = 3'd4
    } state_t;

    state_t                   state_r;
    logic                     init_we_r;
    logic [AW-1:0]            init_addr_r;
    logic [TW-1:0]            time_left_r;
    logic                     round_done_r;
    logic [2:0]               round_winner_r;
    logic [NUM_PLAYERS*W-1:0] wins_r;
    logic [2:0]               match_winner_r;

    logic [2:0]               alive_cnt;
    logic [2:0]               sole_idx;
    logic [W-1:0]             rw_wins;
    logic                     round_over;

    // sole_idx is only meaningful when exactly one player is alive
    always_comb begin
        alive_cnt = 3'd0;
        sole_idx  = DRAW;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            alive_cnt = alive_cnt + {2'b00, bus.alive[i]};
            if (bus.alive[i]) sole_idx = 3'(i);
        end
    end

    // score of the player who took the last round
    always_comb begin
        rw_wins = '0;
        for (int i = 0; i < NUM_PLAYERS; i++)
            if (round_winner_r == 3'(i)) rw_wins = wins_r[i*W +: W];
    end

    // survivor check comes first, so a last survivor on the final tick still wins
    assign round_over = (alive_cnt <= 3'd1) || (bus.tick && time_left_r == TW'(1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r        <= MENU;
            init_we_r      <= 1'b0;
            init_addr_r    <= '0;
            time_left_r    <= '0;
            round_done_r   <= 1'b0;
            round_winner_r <= DRAW;
            wins_r         <= '0;
            match_winner_r <= DRAW;
        end else begin
            round_done_r <= 1'b0;
            if (bus.abort) begin
                state_r        <= MENU;
                init_we_r      <= 1'b0;
                init_addr_r    <= '0;
                wins_r         <= '0;
                match_winner_r <= DRAW;
            end else begin
                case (state_r)
                    MENU: begin
                        if (bus.start) begin
                            state_r     <= INIT;
                            wins_r      <= '0;
                            init_we_r   <= 1'b1;
                            init_addr_r <= '0;
                            time_left_r <= FULL_TIME;
                        end
                    end
                    INIT: begin
                        if (init_addr_r == LAST_ADDR) begin
                            state_r     <= PLAYING;
                            init_we_r   <= 1'b0;
                            init_addr_r <= '0;
                        end else begin
                            init_addr_r <= init_addr_r + AW'(1);
                        end
                    end
                    PLAYING: begin
                        if (bus.tick && time_left_r != '0)
                            time_left_r <= time_left_r - TW'(1);
                        if (round_over) begin
                            state_r      <= ROUND_END;
                            round_done_r <= 1'b1;
                            if (alive_cnt == 3'd1) begin
                                round_winner_r <= sole_idx;
                                for (int i = 0; i < NUM_PLAYERS; i++)
                                    if (sole_idx == 3'(i))
                                        wins_r[i*W +: W] <= wins_r[i*W +: W] + W'(1);
                            end else begin
                                round_winner_r <= DRAW;
                            end
                        end
                    end
                    ROUND_END: begin
                        if (round_winner_r != DRAW && rw_wins == MATCH_WIN) begin
                            state_r        <= MATCH_END;
                            match_winner_r <= round_winner_r;
                        end else if (bus.start) begin
                            state_r     <= INIT;
                            init_we_r   <= 1'b1;
                            init_addr_r <= '0;
                            time_left_r <= FULL_TIME;
                        end
                    end
                    MATCH_END: begin
                        if (bus.start) begin
                            state_r        <= INIT;
                            wins_r         <= '0;
                            round_winner_r <= DRAW;
                            match_winner_r <= DRAW;
                            init_we_r      <= 1'b1;
                            init_addr_r    <= '0;
                            time_left_r    <= FULL_TIME;
                        end
                    end
                    default: state_r <= MENU;
                endcase
            end
        end
    end

    assign bus.state        = state_r;
    assign bus.init_we      = init_we_r;
    assign bus.init_addr    = init_addr_r;
    assign bus.time_left    = time_left_r;
    assign bus.round_done   = round_done_r;
    assign bus.round_winner = round_winner_r;
    assign bus.wins         = wins_r;
    assign bus.match_winner = match_winner_r;
endmodule

// File: tb/tb_round_controller.sv
// tb/tb_round_controller.sv - self-checking bench for round_controller with a score/timer reference model
module tb_round_controller;
    localparam int NP = 4;
    localparam int NB = 15;
    localparam int RT = 8;
    localparam int WM = 2;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    int   exp_wins [NP];
    bit   clear_next;

    round_controller_if #(.NUM_PLAYERS(NP), .NUM_BLOCKS(NB), .ROUND_TICKS(RT), .WINS_TO_MATCH(WM)) bus ();

    round_controller #(.NUM_PLAYERS(NP), .NUM_BLOCKS(NB), .ROUND_TICKS(RT), .WINS_TO_MATCH(WM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_vec();
        logic [7:0] v;
        for (int i = 0; i < NP; i++) v[i*2 +: 2] = 2'(exp_wins[i]);
        return v;
    endfunction

    function automatic int sole_alive(input logic [3:0] a);
        int idx;
        idx = 7;
        if ($countones(a) == 1)
            for (int i = 0; i < NP; i++) if (a[i]) idx = i;
        return idx;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NP; i++) exp_wins[i] = 0;
    endtask

    task automatic wait_playing(output bit ok);
        for (int i = 0; i < 40; i++) begin
            if (bus.state == 3'd2) break;
            step();
        end
        ok = (bus.state == 3'd2);
    endtask

    task automatic begin_round(output bit ok);
        bus.alive = 4'hF;
        bus.tick  = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_playing(ok);
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.start = 1'b1; bus.abort = 1'b1; bus.tick = 1'b1; bus.alive = 4'h0;
        step(); step();
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state); end
        checks++; if (bus.init_we !== 1'b0) begin errors++; $display("FAIL reset_init_we got %0b want 0", bus.init_we); end
        checks++; if (bus.init_addr !== 4'd0) begin errors++; $display("FAIL reset_init_addr got %0d want 0", bus.init_addr); end
        checks++; if (bus.time_left !== 4'd0) begin errors++; $display("FAIL reset_time_left got %0d want 0", bus.time_left); end
        checks++; if (bus.round_done !== 1'b0) begin errors++; $display("FAIL reset_round_done got %0b want 0", bus.round_done); end
        checks++; if (bus.round_winner !== 3'd7) begin errors++; $display("FAIL reset_round_winner got %0d want 7", bus.round_winner); end
        checks++; if (bus.wins !== 8'h00) begin errors++; $display("FAIL reset_wins got %h want 00", bus.wins); end
        checks++; if (bus.match_winner !== 3'd7) begin errors++; $display("FAIL reset_match_winner got %0d want 7", bus.match_winner); end
        reset = 1'b1; bus.start = 1'b0; bus.abort = 1'b0; bus.tick = 1'b0; bus.alive = 4'hF;
        step();
        clear_model();
    endtask

    task automatic test_init();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < NB; k++) begin
            checks++; if (bus.state !== 3'd1 || bus.init_we !== 1'b1 || bus.init_addr !== 4'(k)) begin
                errors++; $display("FAIL init_seq k=%0d got state=%0d we=%0b addr=%0d want 1/1/%0d", k, bus.state, bus.init_we, bus.init_addr, k);
            end
            step();
        end
        checks++; if (bus.state !== 3'd2 || bus.init_we !== 1'b0 || bus.init_addr !== 4'd0) begin
            errors++; $display("FAIL init_exit got state=%0d we=%0b addr=%0d want 2/0/0", bus.state, bus.init_we, bus.init_addr);
        end
        checks++; if (bus.time_left !== 4'(RT)) begin errors++; $display("FAIL init_time_left got %0d want %0d", bus.time_left, RT); end
    endtask

    task automatic test_survivor();
        bus.alive = 4'hF; bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL start_ignored_playing got %0d want 2", bus.state); end
        end
        bus.start = 1'b0;
        bus.alive = 4'b0100;
        step();
        exp_wins[2]++;
        checks++; if (bus.state !== 3'd3 || bus.round_done !== 1'b1) begin
            errors++; $display("FAIL survivor_end got state=%0d done=%0b want 3/1", bus.state, bus.round_done);
        end
        checks++; if (bus.round_winner !== 3'd2) begin errors++; $display("FAIL survivor_winner got %0d want 2", bus.round_winner); end
        checks++; if (bus.wins !== exp_vec()) begin errors++; $display("FAIL survivor_wins got %h want %h", bus.wins, exp_vec()); end
        for (int i = 0; i < 4; i++) begin
            bus.alive = 4'($urandom); bus.tick = 1'($urandom);
            step();
            checks++; if (bus.state !== 3'd3 || bus.round_done !== 1'b0 || bus.wins !== exp_vec()) begin
                errors++; $display("FAIL round_end_hold got state=%0d done=%0b wins=%h want 3/0/%h", bus.state, bus.round_done, bus.wins, exp_vec());
            end
        end
        bus.tick = 1'b0;
    endtask

    task automatic test_timeout();
        bit ok;
        begin_round(ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_reach_playing got state=%0d want 2", bus.state); end
        for (int t = 1; t <= RT; t++) begin
            bus.tick = 1'b1; step(); bus.tick = 1'b0;
            checks++; if (bus.time_left !== 4'(RT - t)) begin errors++; $display("FAIL tick_dec t=%0d got %0d want %0d", t, bus.time_left, RT - t); end
            if (t < RT) begin
                step();
                checks++; if (bus.state !== 3'd2 || bus.time_left !== 4'(RT - t)) begin
                    errors++; $display("FAIL tick_hold t=%0d got state=%0d tl=%0d want 2/%0d", t, bus.state, bus.time_left, RT - t);
                end
            end
        end
        checks++; if (bus.state !== 3'd3 || bus.round_winner !== 3'd7 || bus.wins !== exp_vec()) begin
            errors++; $display("FAIL timeout_draw got state=%0d win=%0d wins=%h want 3/7/%h", bus.state, bus.round_winner, bus.wins, exp_vec());
        end
        begin_round(ok);
        checks++; if (!ok) begin errors++; $display("FAIL coincide_reach_playing got state=%0d want 2", bus.state); end
        for (int t = 1; t < RT; t++) begin bus.tick = 1'b1; step(); end
        bus.alive = 4'b0010;
        step();
        bus.tick = 1'b0;
        exp_wins[1]++;
        checks++; if (bus.state !== 3'd3 || bus.round_winner !== 3'd1 || bus.time_left !== 4'd0 || bus.wins !== exp_vec()) begin
            errors++; $display("FAIL coincide_survivor got state=%0d win=%0d tl=%0d wins=%h want 3/1/0/%h", bus.state, bus.round_winner, bus.time_left, bus.wins, exp_vec());
        end
        begin_round(ok);
        checks++; if (!ok) begin errors++; $display("FAIL alldead_reach_playing got state=%0d want 2", bus.state); end
        bus.alive = 4'b1100; step();
        bus.alive = 4'b0000; step();
        checks++; if (bus.state !== 3'd3 || bus.round_winner !== 3'd7 || bus.wins !== exp_vec()) begin
            errors++; $display("FAIL alldead_draw got state=%0d win=%0d wins=%h want 3/7/%h", bus.state, bus.round_winner, bus.wins, exp_vec());
        end
    endtask

    task automatic test_match();
        bit ok;
        for (int r = 0; r < 2; r++) begin
            begin_round(ok);
            checks++; if (!ok) begin errors++; $display("FAIL match_reach_playing r=%0d got state=%0d want 2", r, bus.state); end
            bus.alive = 4'b1000; step();
            exp_wins[3]++;
            checks++; if (bus.state !== 3'd3 || bus.round_winner !== 3'd3 || bus.match_winner !== 3'd7 || bus.wins !== exp_vec()) begin
                errors++; $display("FAIL match_round r=%0d got state=%0d win=%0d mw=%0d wins=%h want 3/3/7/%h", r, bus.state, bus.round_winner, bus.match_winner, bus.wins, exp_vec());
            end
        end
        step();
        checks++; if (bus.state !== 3'd4 || bus.match_winner !== 3'd3) begin
            errors++; $display("FAIL match_end got state=%0d mw=%0d want 4/3", bus.state, bus.match_winner);
        end
        step();
        checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL match_hold got %0d want 4", bus.state); end
        bus.start = 1'b1; step(); bus.start = 1'b0;
        clear_model();
        checks++; if (bus.state !== 3'd1 || bus.wins !== 8'h00 || bus.round_winner !== 3'd7 || bus.match_winner !== 3'd7) begin
            errors++; $display("FAIL match_restart got state=%0d wins=%h win=%0d mw=%0d want 1/00/7/7", bus.state, bus.wins, bus.round_winner, bus.match_winner);
        end
        bus.alive = 4'hF;
        wait_playing(ok);
        bus.abort = 1'b1; step(); bus.abort = 1'b0;
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL match_abort got %0d want 0", bus.state); end
        clear_next = 1'b1;
    endtask

    task automatic test_random_rounds();
        bit ok;
        bit done;
        int tl;
        int cnt;
        int w;
        bit ends;
        logic [3:0] a;
        for (int r = 0; r < 14; r++) begin
            if (clear_next) clear_model();
            begin_round(ok);
            checks++; if (!ok || bus.time_left !== 4'(RT) || bus.wins !== exp_vec()) begin
                errors++; $display("FAIL rnd_start r=%0d got state=%0d tl=%0d wins=%h want 2/%0d/%h", r, bus.state, bus.time_left, bus.wins, RT, exp_vec());
            end
            clear_next = 1'b0;
            tl = RT; done = 1'b0; a = 4'hF;
            for (int c = 0; c < 300 && !done; c++) begin
                if ($urandom_range(3) == 0) a = a & ~(4'b0001 << $urandom_range(3));
                if ($urandom_range(15) == 0) a = a & 4'($urandom);
                bus.alive = a;
                bus.tick  = ($urandom_range(2) == 0);
                cnt  = $countones(a);
                ends = (cnt <= 1) || (bus.tick && tl == 1);
                if (bus.tick && tl > 0) tl--;
                step();
                if (ends) begin
                    done = 1'b1;
                    w = sole_alive(a);
                    if (w != 7) exp_wins[w]++;
                    checks++; if (bus.state !== 3'd3 || bus.round_done !== 1'b1 || bus.round_winner !== 3'(w) || bus.wins !== exp_vec() || bus.time_left !== 4'(tl)) begin
                        errors++; $display("FAIL rnd_end r=%0d got state=%0d done=%0b win=%0d wins=%h tl=%0d want 3/1/%0d/%h/%0d", r, bus.state, bus.round_done, bus.round_winner, bus.wins, bus.time_left, w, exp_vec(), tl);
                    end
                end else begin
                    checks++; if (bus.state !== 3'd2 || bus.time_left !== 4'(tl)) begin
                        errors++; $display("FAIL rnd_play r=%0d c=%0d got state=%0d tl=%0d want 2/%0d", r, c, bus.state, bus.time_left, tl);
                    end
                end
            end
            checks++; if (!done) begin errors++; $display("FAIL rnd_timeout r=%0d got no round end want end within bound", r); end
            bus.tick = 1'b0;
            step();
            if (w != 7 && exp_wins[w] == WM) begin
                clear_next = 1'b1;
                checks++; if (bus.state !== 3'd4 || bus.match_winner !== 3'(w)) begin
                    errors++; $display("FAIL rnd_match r=%0d got state=%0d mw=%0d want 4/%0d", r, bus.state, bus.match_winner, w);
                end
            end else begin
                checks++; if (bus.state !== 3'd3 || bus.round_done !== 1'b0 || bus.match_winner !== 3'd7) begin
                    errors++; $display("FAIL rnd_hold r=%0d got state=%0d done=%0b mw=%0d want 3/0/7", r, bus.state, bus.round_done, bus.match_winner);
                end
            end
        end
    endtask

    task automatic test_abort_and_reset();
        bit ok;
        if (clear_next) clear_model();
        begin_round(ok);
        clear_next = 1'b0;
        bus.alive = 4'b0001; step();
        exp_wins[0]++;
        checks++; if (!ok || bus.wins !== exp_vec()) begin errors++; $display("FAIL abort_setup got wins=%h want %h", bus.wins, exp_vec()); end
        if (exp_wins[0] == WM) begin step(); clear_model(); end
        begin_round(ok);
        bus.tick = 1'b1; step(); step(); bus.tick = 1'b0;
        bus.abort = 1'b1; bus.start = 1'b1; bus.alive = 4'b0000;
        step();
        bus.abort = 1'b0; bus.start = 1'b0; bus.alive = 4'hF;
        checks++; if (bus.state !== 3'd0 || bus.wins !== 8'h00 || bus.init_we !== 1'b0 || bus.round_done !== 1'b0) begin
            errors++; $display("FAIL abort_playing got state=%0d wins=%h we=%0b done=%0b want 0/00/0/0", bus.state, bus.wins, bus.init_we, bus.round_done);
        end
        clear_model();
        bus.start = 1'b1; step(); bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.init_addr == 4'd7) break;
            step();
        end
        checks++; if (bus.state !== 3'd1 || bus.init_addr !== 4'd7) begin
            errors++; $display("FAIL reach_addr7 got state=%0d addr=%0d want 1/7", bus.state, bus.init_addr);
        end
        reset = 1'b0; bus.abort = 1'b1; bus.start = 1'b1;
        step();
        checks++; if (bus.state !== 3'd0 || bus.init_we !== 1'b0 || bus.init_addr !== 4'd0 || bus.time_left !== 4'd0 || bus.round_winner !== 3'd7) begin
            errors++; $display("FAIL reset_mid_init got state=%0d we=%0b addr=%0d tl=%0d win=%0d want 0/0/0/0/7", bus.state, bus.init_we, bus.init_addr, bus.time_left, bus.round_winner);
        end
        reset = 1'b1; bus.abort = 1'b0; bus.start = 1'b0;
        step();
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL menu_idle got %0d want 0", bus.state); end
    endtask

    initial begin
        reset = 1'b1; bus.start = 1'b0; bus.abort = 1'b0; bus.tick = 1'b0; bus.alive = 4'hF;
        clear_next = 1'b0;
        clear_model();
        test_reset();
        test_init();
        test_survivor();
        test_timeout();
        test_match();
        test_random_rounds();
        test_abort_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
